// File: rtl/regbank_arbiter.sv
// Two-client arbiter in front of the register bank: client 0 has fixed priority,
// a starvation counter forces a client-1 win after MAX_WAIT back-to-back losses.
module regbank_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  req0_i,
   input  logic                  req1_i,
   input  logic                  we0_i,
   input  logic                  we1_i,
   input  logic [ADDR_WIDTH-1:0] addr_a0_i,
   input  logic [ADDR_WIDTH-1:0] addr_a1_i,
   input  logic [ADDR_WIDTH-1:0] addr_b0_i,
   input  logic [ADDR_WIDTH-1:0] addr_b1_i,
   input  logic [DATA_WIDTH-1:0] wdata0_i,
   input  logic [DATA_WIDTH-1:0] wdata1_i,
   output logic                  gnt0_o,
   output logic                  gnt1_o,
   output logic                  done0_o,
   output logic                  done1_o,
   output logic [DATA_WIDTH-1:0] rdata_a0_o,
   output logic [DATA_WIDTH-1:0] rdata_a1_o,
   output logic [DATA_WIDTH-1:0] rdata_b0_o,
   output logic [DATA_WIDTH-1:0] rdata_b1_o,
   output logic                  busy_o,
   output logic [ADDR_WIDTH-1:0] rb_address_o,
   output logic [ADDR_WIDTH-1:0] rb_addressB_o,
   output logic                  rb_enable_write_o,
   output logic                  rb_enable_read_o,
   output logic [DATA_WIDTH-1:0] rb_in_data_o,
   output logic [DATA_WIDTH-1:0] rb_in_dataB_o,
   input  logic [DATA_WIDTH-1:0] rb_out_data_i,
   input  logic [DATA_WIDTH-1:0] rb_out_dataB_i,
   output logic [1:0]            state_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   state_e                state_q, state_d;
   logic [3:0]            starve_q, starve_d;
   logic                  win_q, win_d;
   logic                  we_q, we_d;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  done0_q, done0_d, done1_q, done1_d;
   logic                  busy_q, busy_d;
   logic                  en_wr_q, en_wr_d, en_rd_q, en_rd_d;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rda0_q, rda0_d, rdb0_q, rdb0_d;
   logic [DATA_WIDTH-1:0] rda1_q, rda1_d, rdb1_q, rdb1_d;
   logic                  pick1;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr_a;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         starve_q <= '0;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         en_wr_q  <= 1'b0;
         en_rd_q  <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         wdata_q  <= '0;
         rda0_q   <= '0;
         rdb0_q   <= '0;
         rda1_q   <= '0;
         rdb1_q   <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         win_q    <= win_d;
         we_q     <= we_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         en_wr_q  <= en_wr_d;
         en_rd_q  <= en_rd_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         wdata_q  <= wdata_d;
         rda0_q   <= rda0_d;
         rdb0_q   <= rdb0_d;
         rda1_q   <= rda1_d;
         rdb1_q   <= rdb1_d;
      end
   end

   assign pick1      = req1_i && (!req0_i || (starve_q == MAX_W));
   assign sel_we     = pick1 ? we1_i : we0_i;
   assign sel_addr_a = pick1 ? addr_a1_i : addr_a0_i;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      win_d    = win_q;
      we_d     = we_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      en_wr_d  = 1'b0;
      en_rd_d  = 1'b0;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      wdata_d  = wdata_q;
      rda0_d   = rda0_q;
      rdb0_d   = rdb0_q;
      rda1_d   = rda1_q;
      rdb1_d   = rdb1_q;
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               win_d    = pick1;
               we_d     = sel_we;
               addr_a_d = sel_addr_a;
               addr_b_d = pick1 ? addr_b1_i : addr_b0_i;
               wdata_d  = pick1 ? wdata1_i : wdata0_i;
               gnt0_d   = !pick1;
               gnt1_d   = pick1;
               en_rd_d  = !sel_we;
               // r0 is hardwired zero: a write to it never reaches the bank
               en_wr_d  = sel_we && (sel_addr_a != '0);
               if (req0_i && req1_i && !pick1)
                  starve_d = (starve_q == MAX_W) ? starve_q : starve_q + 4'd1;
               else
                  starve_d = '0;
               state_d  = ACCESS;
            end
         end
         ACCESS: state_d = CAPTURE;
         CAPTURE: begin
            if (!we_q) begin
               if (win_q) begin
                  rda1_d = rb_out_data_i;
                  rdb1_d = rb_out_dataB_i;
               end else begin
                  rda0_d = rb_out_data_i;
                  rdb0_d = rb_out_dataB_i;
               end
            end
            done0_d = !win_q;
            done1_d = win_q;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign gnt0_o            = gnt0_q;
   assign gnt1_o            = gnt1_q;
   assign done0_o           = done0_q;
   assign done1_o           = done1_q;
   assign rdata_a0_o        = rda0_q;
   assign rdata_b0_o        = rdb0_q;
   assign rdata_a1_o        = rda1_q;
   assign rdata_b1_o        = rdb1_q;
   assign busy_o            = busy_q;
   assign rb_address_o      = addr_a_q;
   assign rb_addressB_o     = addr_b_q;
   assign rb_enable_write_o = en_wr_q;
   assign rb_enable_read_o  = en_rd_q;
   assign rb_in_data_o      = wdata_q;
   assign rb_in_dataB_o     = '0;
   assign state_o           = state_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: behavioural register bank, directed accesses, and a
// negedge monitor popping expected grants/completions from scoreboard queues.
module tb_regbank_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   // Clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [AW-1:0] addr_a0 = '0, addr_a1 = '0, addr_b0 = '0, addr_b1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, done0, done1, busy;
   logic [DW-1:0] rdata_a0, rdata_a1, rdata_b0, rdata_b1;
   logic [AW-1:0] rb_addr, rb_addrB;
   logic          rb_we, rb_re;
   logic [DW-1:0] rb_in, rb_inB;
   logic [DW-1:0] rb_out = '0, rb_outB = '0;
   logic [1:0]    state;

   regbank_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
      .clock_i(clk), .reset_ni(rst_n),
      .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
      .addr_a0_i(addr_a0), .addr_a1_i(addr_a1), .addr_b0_i(addr_b0), .addr_b1_i(addr_b1),
      .wdata0_i(wdata0), .wdata1_i(wdata1),
      .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
      .rdata_a0_o(rdata_a0), .rdata_a1_o(rdata_a1), .rdata_b0_o(rdata_b0), .rdata_b1_o(rdata_b1),
      .busy_o(busy), .rb_address_o(rb_addr), .rb_addressB_o(rb_addrB),
      .rb_enable_write_o(rb_we), .rb_enable_read_o(rb_re),
      .rb_in_data_o(rb_in), .rb_in_dataB_o(rb_inB),
      .rb_out_data_i(rb_out), .rb_out_dataB_i(rb_outB), .state_o(state)
   );

   // Register bank: plain memory with registered read (r0 deliberately not protected)
   logic [DW-1:0] mem [32];
   initial for (int i = 0; i < 32; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (rb_we) mem[rb_addr] <= rb_in;
      if (rb_re) begin
         rb_out  <= mem[rb_addr];
         rb_outB <= mem[rb_addrB];
      end
   end

   // Scoreboard
   typedef struct packed {
      logic          c;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } done_t;
   done_t         exp_q[$];
   logic          exp_gnt_q[$];
   logic [DW-1:0] model_a[2];
   logic [DW-1:0] model_b[2];
   int            pass_cnt = 0;
   int            total_cnt = 0;
   int            cyc = 0;
   int            last_gnt_cyc = -100;
   bit            zero_write_seen = 0;
   bit            r5_write_seen = 0;

   task automatic check(input string name, input bit ok, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (rb_we && rb_addr == '0) zero_write_seen = 1;
         if (rb_we && rb_addr == 5'd5) r5_write_seen = 1;
         if (gnt0 || gnt1) begin
            if (exp_gnt_q.size() == 0) begin
               check("unexpected_gnt", 0, {gnt1, gnt0}, 0);
            end else begin
               logic ec;
               ec = exp_gnt_q.pop_front();
               check("gnt_client", (gnt1 == ec) && (gnt0 == !ec), {gnt1, gnt0}, {ec, !ec});
               check("gnt_spacing", (cyc - last_gnt_cyc) >= 4, cyc - last_gnt_cyc, 4);
            end
            last_gnt_cyc = cyc;
         end
         if (done0 || done1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 0, {done1, done0}, 0);
            end else begin
               done_t e;
               e = exp_q.pop_front();
               check("done_client", (done1 == e.c) && (done0 == !e.c), {done1, done0}, {e.c, !e.c});
               check("rdata_a", (e.c ? rdata_a1 : rdata_a0) == e.a, e.c ? rdata_a1 : rdata_a0, e.a);
               check("rdata_b", (e.c ? rdata_b1 : rdata_b0) == e.b, e.c ? rdata_b1 : rdata_b0, e.b);
            end
         end
      end
   end

   // Driver tasks
   task automatic drive(input bit c, input bit r, input bit we, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [DW-1:0] wd);
      if (c) begin
         req1 = r; we1 = we; addr_a1 = a; addr_b1 = b; wdata1 = wd;
      end else begin
         req0 = r; we0 = we; addr_a0 = a; addr_b0 = b; wdata0 = wd;
      end
   endtask

   task automatic access(input bit c, input bit we, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] wd, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                         input bit drop_early);
      int n;
      if (!we) begin
         model_a[c] = ea;
         model_b[c] = eb;
      end
      exp_gnt_q.push_back(c);
      exp_q.push_back('{c: c, a: model_a[c], b: model_b[c]});
      @(negedge clk);
      drive(c, 1, we, a, b, wd);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(c ? gnt1 : gnt0) && n < 8);
      check("gnt_latency", n == 1, n, 1);
      check("busy_during_access", busy == 1'b1, busy, 1);
      n = 0;
      if (drop_early) begin
         @(negedge clk);
         n = 1;
         drive(c, 0, we, a, b, wd);
      end
      do begin
         @(negedge clk);
         n++;
      end while (!(c ? done1 : done0) && n < 8);
      check("done_latency", n == 2, n, 2);
      drive(c, 0, we, a, b, wd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic ord [10];
      model_a[0] = '0; model_a[1] = '0; model_b[0] = '0; model_b[1] = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {gnt0, gnt1, done0, done1, busy, rb_we, rb_re} == 7'd0,
            {gnt0, gnt1, done0, done1, busy, rb_we, rb_re}, 0);
      check("reset_state", state == 2'd0, state, 0);
      rst_n = 1'b1;

      // Client 0 write then read
      access(0, 1, 5'd5, 5'd0, 32'hDEADBEEF, '0, '0, 0);
      access(0, 0, 5'd5, 5'd0, '0, 32'hDEADBEEF, 32'h0, 0);

      // Client 1 alone: write to r0 dropped, read r0 returns zero
      access(1, 1, 5'd0, 5'd0, 32'h12345678, '0, '0, 0);
      access(1, 0, 5'd0, 5'd5, '0, 32'h0, 32'hDEADBEEF, 0);
      check("other_rdata_holds", rdata_a0 == 32'hDEADBEEF, rdata_a0, 32'hDEADBEEF);

      // Both clients requesting continuously
      ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      model_a[0] = 32'hDEADBEEF; model_b[0] = '0;
      model_a[1] = 32'hDEADBEEF; model_b[1] = '0;
      for (int i = 0; i < 10; i++) begin
         exp_gnt_q.push_back(ord[i]);
         exp_q.push_back('{c: ord[i], a: 32'hDEADBEEF, b: 32'h0});
      end
      @(negedge clk);
      drive(0, 1, 0, 5'd5, 5'd0, '0);
      drive(1, 1, 0, 5'd5, 5'd0, '0);
      k = 0;
      for (int t = 0; t < 80 && k < 10; t++) begin
         @(negedge clk);
         if (done0 || done1) k++;
      end
      drive(0, 0, 0, 5'd5, 5'd0, '0);
      drive(1, 0, 0, 5'd5, 5'd0, '0);
      check("starve_done_count", k == 10, k, 10);

      // Reset during the access cycle of a write to r7
      @(negedge clk);
      exp_gnt_q.push_back(0);
      drive(0, 1, 1, 5'd7, 5'd0, 32'hCAFE0007);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!gnt0 && k < 8);
      check("abort_gnt_latency", k == 1, k, 1);
      check("abort_write_enabled", rb_we == 1'b1, rb_we, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs_zero",
            {gnt0, gnt1, done0, done1, busy, rb_we, rb_re, |rdata_a0, |rdata_a1, |rdata_b0, |rdata_b1} == '0,
            {gnt0, gnt1, done0, done1, busy, rb_we, rb_re, |rdata_a0, |rdata_a1, |rdata_b0, |rdata_b1}, 0);
      check("abort_state_idle", state == 2'd0, state, 0);
      drive(0, 0, 0, '0, '0, '0);
      model_a[0] = '0; model_a[1] = '0; model_b[0] = '0; model_b[1] = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      access(0, 0, 5'd7, 5'd5, '0, 32'h0, 32'hDEADBEEF, 0);

      // req0 dropped right after its grant
      access(0, 0, 5'd5, 5'd7, '0, 32'hDEADBEEF, 32'h0, 1);
      repeat (8) @(negedge clk);
      check("idle_after_drop", state == 2'd0, state, 0);

      check("no_r0_write", zero_write_seen == 0, zero_write_seen, 0);
      check("r5_write_seen", r5_write_seen == 1, r5_write_seen, 1);
      check("gnt_queue_empty", exp_gnt_q.size() == 0, exp_gnt_q.size(), 0);
      check("done_queue_empty", exp_q.size() == 0, exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Shares the single register bank (two address ports, one write path, registered read) between two requesters: client 0 (core pipeline) and client 1 (debug/loader).
- Sequences each access as issue, bank access and response, then returns read data to the winning client.
- Client 0 has fixed priority; a starvation counter guarantees client 1 progress.
- Sits between the core control/debug logic and the register bank instance.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width
- MAX_WAIT, 4, consecutive client-0 wins tolerated while client 1 is requesting (legal range 1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held high until the matching done
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr_a0 / addr_a1  in  ADDR_WIDTH  write address, or read address A
- addr_b0 / addr_b1  in  ADDR_WIDTH  read address B
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted
- done0 / done1  out  1  one-cycle pulse: access complete, rdata valid for reads
- rdata_a0 / rdata_a1, rdata_b0 / rdata_b1  out  DATA_WIDTH  read results, held until the client's next done
- busy  out  1  high whenever the FSM is not IDLE
- rb_address, rb_addressB  out  ADDR_WIDTH  to bank address, addressB
- rb_enable_write, rb_enable_read  out  1  to bank enables
- rb_in_data, rb_in_dataB  out  DATA_WIDTH  to bank in_data, in_dataB (in_dataB is always 0)
- rb_out_data, rb_out_dataB  in  DATA_WIDTH  from bank outputs; valid in the cycle after rb_enable_read is high

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, FSM to IDLE, starve_cnt 0, winner register 0.
  - Reset mid-operation aborts the access; no done is issued; the bank enables drop immediately.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. All outputs are registered.
- IDLE:
  - If any req is high, arbitrate and latch winner, we, addresses and wdata.
  - Drive the rb_* address/data/enable registers and pulse gnt_winner; next state ACCESS.
  - With no req, stay in IDLE with bank enables 0.
- Arbitration:
  - Client 1 wins if req1 && (!req0 || starve_cnt == MAX_WAIT); otherwise client 0 wins.
  - starve_cnt increments, saturating at MAX_WAIT, when req0 and req1 are both high and client 0 wins.
  - starve_cnt clears when client 1 wins or when req1 is low during arbitration.
- ACCESS (one cycle):
  - Read: rb_enable_read=1 and rb_enable_write=0.
  - Write: rb_enable_write=1, except when the write address is 0, where it stays 0 (r0 is hardwired zero and the write is silently dropped).
  - Next state CAPTURE; the enables are cleared at its entry.
- CAPTURE: for a read, latch rb_out_data into rdata_a and rb_out_dataB into rdata_b of the winner; next state RESP.
- RESP: done_winner=1 for one cycle; next state IDLE; new arbitration happens in the following cycle.
- Latency:
  - req sampled in IDLE at edge T, with gnt visible in cycle T+1 and done visible in cycle T+3.
  - Minimum spacing between grants is 4 cycles; busy is high for 3 cycles per access.
- Handshake and request rules:
  - A req that drops after gnt does not cancel the access; done is still pulsed.
  - A req still high in the cycle after done is treated as a new request.
  - Only the winner's gnt/done/rdata change; the other client's rdata holds its value.
- Simultaneous requests in the same cycle are resolved purely by the arbitration rule; there is no queueing beyond the req level.
- rb_address and rb_addressB hold their last values outside ACCESS. rb_in_dataB is tied to 0.

Test Plan:
- After reset release, client 0 writes 0xDEADBEEF to r5; client 0 then reads addr_a=5, addr_b=0 -> gnt0 at T+1, done0 at T+3, rdata_a0=0xDEADBEEF, rdata_b0=0.
- Client 1 writes 0x12345678 to r0, then reads r0 -> rb_enable_write never asserts; read returns 0; done1 still pulses.
- req0 and req1 held high continuously, MAX_WAIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1; no two grants closer than 4 cycles.
- Only req1 high -> client 1 is granted at the first IDLE cycle with starve_cnt=0; gnt0 and done0 stay 0.
- Reset asserted during ACCESS of a write to r7 -> all outputs 0 immediately; no done; after release, the next request is granted normally.
- req0 dropped in the cycle after gnt0 -> done0 still pulses at T+3; FSM returns to IDLE; no re-grant.
